ram_ctrl: RTL and testbench
===========================

# ram_ctrl

Parametrised single-port synchronous RAM with a valid/ready request handshake, per-byte write strobes, a configurable read-latency pipeline and an optional post-reset clear sequencer. It is the next-generation replacement for the fixed 8-bit-address / 16-bit-data memory. It serves as instruction/data storage behind the CPU load/store path, and any requester that can tolerate fixed-latency responses.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words
- READ_LATENCY, 1, cycles from read accept to response; legal 1..4
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents untouched

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller accepts a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  DATA_WIDTH/8  byte-lane enables; bit i covers wdata[8i+7:8i]
- rsp_valid  out  1  one-cycle pulse; read data valid
- rsp_rdata  out  DATA_WIDTH  read data; holds last value between pulses
- busy  out  1  clear sequence in progress

## Operation
- FSM states: CLEAR, READY.
- Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
- CLEAR:
  - writes 0 to one word per cycle, counter 0 → 2**ADDR_WIDTH-1, no wrap.
  - busy=1 and req_ready=0 throughout.
  - Transitions to READY after the last word is written.
- READY:
  - req_ready=1 continuously; no internal back-pressure.
  - Accept = req_valid && req_ready at the rising edge.
- Write:
  - Only lanes with the strobe set are updated; other lanes keep their old value.
  - wstrb=0 is a legal no-op.
  - Writes produce no response.
- Read:
  - The address is captured at accept.
  - The word enters the valid/data shift pipeline of depth READY_LATENCY-stage count READ_LATENCY.
  - One request per cycle is accepted, reads and writes in any mix.
  - Responses come back strictly in accept order.
- Read-after-write to the same address, accepted the next cycle, returns the new data. A read never sees a partially-written word.
- Reset mid-operation:
  - In-flight reads are dropped, with no response pulse.
  - A reset during CLEAR restarts the clear from address 0.
- Reset does not clear memory when CLEAR_ON_RESET=0.

## Timing
- Reset values:
  - req_ready=0 during the rst cycle.
  - After reset: req_ready=!CLEAR_ON_RESET, busy=CLEAR_ON_RESET.
  - rsp_valid=0, rsp_rdata=0, clear counter=0, read pipeline valids=0.
- Clear duration is exactly 2**ADDR_WIDTH cycles after rst deasserts. req_ready rises on the following cycle; busy falls in the same cycle.
- Read accepted at edge N: rsp_valid=1 and rsp_rdata valid during the cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY edges later. Full throughput is one response per cycle.
- Write accepted at edge N is visible to a read accepted at edge N+1.
- req_* inputs are ignored when req_ready=0.

## Structure
- Shared package mem_pkg holds:
  - the state typedef (CLEAR, READY)
  - the constant MAX_READ_LATENCY=4
  - a strobe-width helper function (DATA_WIDTH/8)
- Sub-module ram_ctrl_rd_pipe: parametrised valid+data shift register of depth READ_LATENCY, with synchronous flush on rst.
- Storage is an inferred array in ram_ctrl, with byte-lane write loop.
- Elaboration-time check: DATA_WIDTH%8==0 and 1≤READ_LATENCY≤4.

## Test plan
- Default params, rst pulse:
  - busy=1 for 256 cycles, req_ready rises on the next cycle.
  - Read 0x00 and 0xFF: both return 0x0000.
- Write 0x1234 @0x00 with wstrb=2'b11, read 0x00 on the next cycle → rsp_valid one cycle later, rsp_rdata=0x1234.
- Write 0xABCD @0xFF, then write 0x0099 @0xFF with wstrb=2'b01, read 0xFF → 0xAB99. A write with wstrb=2'b00 leaves the word unchanged.
- READ_LATENCY=3, back-to-back reads of 0x00 (0x1234) and 0xFF (0xAB99) at edges N and N+1 → responses in that order, 3 and 4 edges later. rsp_rdata holds 0xAB99 afterwards.
- Assert rst at clear cycle 100 → counter restarts; busy stays high a further 256 cycles. Assert rst with 2 reads in flight → no rsp_valid pulse.
- CLEAR_ON_RESET=0 → req_ready=1 immediately after reset and busy never asserts. A word previously written to 0x10 with 0x5A5A reads back 0x5A5A after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared state type, latency limit and strobe-width helper for ram_ctrl
package mem_pkg;
   typedef enum logic {CLEAR, READY} state_t;
   localparam int MAX_READ_LATENCY = 4;
   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction
endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: request/response bus between a requester and ram_ctrl
interface ram_ctrl_if
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                                req_valid;
   logic                                req_ready;
   logic                                req_write;
   logic [ADDR_WIDTH-1:0]               req_addr;
   logic [DATA_WIDTH-1:0]               req_wdata;
   logic [strb_width(DATA_WIDTH)-1:0]   req_wstrb;
   logic                                rsp_valid;
   logic [DATA_WIDTH-1:0]               rsp_rdata;
   logic                                busy;
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  req_ready, rsp_valid, rsp_rdata, busy
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output req_ready, rsp_valid, rsp_rdata, busy
   );
endinterface

// File: rtl/ram_ctrl_rd_pipe.sv
// ram_ctrl_rd_pipe: valid+data shift register carrying read responses, flushed by rst
module ram_ctrl_rd_pipe #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);
   logic [DEPTH-1:0]            r_valid;
   logic [DEPTH-1:0][WIDTH-1:0] r_data;
   // data moves only alongside a valid, so the last stage holds its value between pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_data  <= '0;
      end else begin
         r_valid[0] <= i_valid;
         if (i_valid) r_data[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            if (r_valid[i-1]) r_data[i] <= r_data[i-1];
         end
      end
   end
   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];
endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port RAM with byte strobes, fixed read latency and post-reset clear
module ram_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 8,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic       clk,
   input  logic       rst,
   ram_ctrl_if.slave  bus
);
   localparam int SW = strb_width(DATA_WIDTH);
   if (DATA_WIDTH % 8 != 0 || READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_param
      $error("ram_ctrl: DATA_WIDTH must be a multiple of 8 and READ_LATENCY within 1..4");
   end
   state_t                  r_state, w_next;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic [DATA_WIDTH-1:0]   r_mem [2**ADDR_WIDTH];
   logic                    w_ready, w_busy, w_accept;
   // state register and clear address counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == CLEAR) ? r_cnt + 1'b1 : r_cnt;
      end
   end
   // leave CLEAR once the top word has been zeroed; ready is masked while rst is high
   always_comb begin
      w_next  = (r_state == CLEAR && &r_cnt) ? READY : r_state;
      w_ready = (r_state == READY) && !rst;
      w_busy  = (r_state == CLEAR);
   end
   assign w_accept      = bus.req_valid && w_ready;
   assign bus.req_ready = w_ready;
   assign bus.busy      = w_busy;
   // storage: clear sweep or strobed write; contents are not reset
   always_ff @(posedge clk) begin
      if (r_state == CLEAR && !rst)
         r_mem[r_cnt] <= '0;
      else if (w_accept && bus.req_write)
         for (int i = 0; i < SW; i++)
            if (bus.req_wstrb[i]) r_mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
   end
   ram_ctrl_rd_pipe #(.DEPTH(READ_LATENCY), .WIDTH(DATA_WIDTH)) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_accept && !bus.req_write),
      .i_data  (r_mem[bus.req_addr]),
      .o_valid (bus.rsp_valid),
      .o_data  (bus.rsp_rdata)
   );
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed checks of three ram_ctrl configurations driven by one shared stimulus
module tb_ram_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        v = 1'b0, w = 1'b0;
   logic [7:0]  a = '0;
   logic [15:0] d = '0;
   logic [1:0]  s = '0;
   int          n_vec = 0, n_bad = 0;
   always #5 clk = ~clk;
   ram_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) ia ();
   ram_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) ib ();
   ram_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) ic ();
   assign ia.req_valid = v; assign ia.req_write = w; assign ia.req_addr = a; assign ia.req_wdata = d; assign ia.req_wstrb = s;
   assign ib.req_valid = v; assign ib.req_write = w; assign ib.req_addr = a; assign ib.req_wdata = d; assign ib.req_wstrb = s;
   assign ic.req_valid = v; assign ic.req_write = w; assign ic.req_addr = a; assign ic.req_wdata = d; assign ic.req_wstrb = s;
   ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_a (.clk(clk), .rst(rst), .bus(ia));
   ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) u_b (.clk(clk), .rst(rst), .bus(ib));
   ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u_c (.clk(clk), .rst(rst), .bus(ic));

   task automatic tick;
      @(posedge clk); #1;
   endtask
   task automatic drive(input logic iv, input logic iw, input logic [7:0] ia_, input logic [15:0] id, input logic [1:0] is);
      v = iv; w = iw; a = ia_; d = id; s = is;
   endtask

   task automatic test_reset;
      int cnt = 0;
      rst = 1'b1; drive(0, 0, 0, 0, 0);
      tick; tick;
      n_vec++; if (ic.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_c got %b want 0", ic.req_ready); end
      n_vec++; if (ia.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_a got %b want 0", ia.req_ready); end
      n_vec++; if (ia.rsp_valid !== 1'b0 || ia.rsp_rdata !== 16'h0) begin n_bad++; $display("FAIL rst_rsp_a got %b/%h want 0/0000", ia.rsp_valid, ia.rsp_rdata); end
      n_vec++; if (ib.rsp_valid !== 1'b0 || ib.rsp_rdata !== 16'h0) begin n_bad++; $display("FAIL rst_rsp_b got %b/%h want 0/0000", ib.rsp_valid, ib.rsp_rdata); end
      rst = 1'b0; #1;
      n_vec++; if (ic.req_ready !== 1'b1 || ic.busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_c ready/busy got %b/%b want 1/0", ic.req_ready, ic.busy); end
      n_vec++; if (ia.req_ready !== 1'b0 || ia.busy !== 1'b1) begin n_bad++; $display("FAIL post_rst_a ready/busy got %b/%b want 0/1", ia.req_ready, ia.busy); end
      drive(1, 1, 8'h00, 16'hFFFF, 2'b11);
      while (ia.busy === 1'b1 && cnt < 1000) begin cnt++; tick; end
      drive(0, 0, 0, 0, 0);
      n_vec++; if (cnt != 256) begin n_bad++; $display("FAIL clear_len got %0d want 256", cnt); end
      n_vec++; if (ia.req_ready !== 1'b1 || ib.busy !== 1'b0) begin n_bad++; $display("FAIL clear_done ready_a/busy_b got %b/%b want 1/0", ia.req_ready, ib.busy); end
      drive(1, 0, 8'h00, 0, 0); tick;
      n_vec++; if (ia.rsp_valid !== 1'b1 || ia.rsp_rdata !== 16'h0000) begin n_bad++; $display("FAIL rd_clr_00 got %b/%h want 1/0000", ia.rsp_valid, ia.rsp_rdata); end
      drive(1, 0, 8'hFF, 0, 0); tick;
      n_vec++; if (ia.rsp_valid !== 1'b1 || ia.rsp_rdata !== 16'h0000) begin n_bad++; $display("FAIL rd_clr_ff got %b/%h want 1/0000", ia.rsp_valid, ia.rsp_rdata); end
      drive(0, 0, 0, 0, 0); tick;
      n_vec++; if (ia.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rsp_pulse got %b want 0", ia.rsp_valid); end
   endtask

   task automatic test_raw;
      drive(1, 1, 8'h00, 16'h1234, 2'b11); tick;
      n_vec++; if (ia.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL write_no_rsp got %b want 0", ia.rsp_valid); end
      drive(1, 0, 8'h00, 0, 0); tick;
      n_vec++; if (ia.rsp_valid !== 1'b1 || ia.rsp_rdata !== 16'h1234) begin n_bad++; $display("FAIL raw_a got %b/%h want 1/1234", ia.rsp_valid, ia.rsp_rdata); end
      n_vec++; if (ic.rsp_valid !== 1'b1 || ic.rsp_rdata !== 16'h1234) begin n_bad++; $display("FAIL raw_c got %b/%h want 1/1234", ic.rsp_valid, ic.rsp_rdata); end
      drive(0, 0, 0, 0, 0); tick;
      n_vec++; if (ia.rsp_valid !== 1'b0 || ia.rsp_rdata !== 16'h1234) begin n_bad++; $display("FAIL raw_hold got %b/%h want 0/1234", ia.rsp_valid, ia.rsp_rdata); end
   endtask

   task automatic test_strobe;
      drive(1, 1, 8'hFF, 16'hABCD, 2'b11); tick;
      drive(1, 1, 8'hFF, 16'h0099, 2'b01); tick;
      drive(1, 0, 8'hFF, 0, 0); tick;
      n_vec++; if (ia.rsp_valid !== 1'b1 || ia.rsp_rdata !== 16'hAB99) begin n_bad++; $display("FAIL strb_lo_a got %b/%h want 1/ab99", ia.rsp_valid, ia.rsp_rdata); end
      n_vec++; if (ic.rsp_rdata !== 16'hAB99) begin n_bad++; $display("FAIL strb_lo_c got %h want ab99", ic.rsp_rdata); end
      drive(1, 1, 8'hFF, 16'hFFFF, 2'b00); tick;
      drive(1, 1, 8'hFF, 16'h7700, 2'b10); tick;
      drive(1, 0, 8'hFF, 0, 0); tick;
      n_vec++; if (ia.rsp_rdata !== 16'h7799) begin n_bad++; $display("FAIL strb_hi got %h want 7799", ia.rsp_rdata); end
      drive(1, 1, 8'hFF, 16'hAB00, 2'b10); tick;
      drive(1, 1, 8'hFF, 16'h1111, 2'b00); tick;
      drive(1, 0, 8'hFF, 0, 0); tick;
      n_vec++; if (ia.rsp_valid !== 1'b1 || ia.rsp_rdata !== 16'hAB99) begin n_bad++; $display("FAIL strb_zero got %b/%h want 1/ab99", ia.rsp_valid, ia.rsp_rdata); end
      drive(1, 1, 8'h10, 16'h5A5A, 2'b11); tick;
      drive(0, 0, 0, 0, 0); tick; tick; tick; tick;
   endtask

   task automatic test_back_to_back;
      drive(1, 0, 8'h00, 0, 0); tick;
      n_vec++; if (ia.rsp_valid !== 1'b1 || ia.rsp_rdata !== 16'h1234 || ib.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_n a=%b/%h b_valid=%b want 1/1234 0", ia.rsp_valid, ia.rsp_rdata, ib.rsp_valid); end
      drive(1, 0, 8'hFF, 0, 0); tick;
      n_vec++; if (ia.rsp_rdata !== 16'hAB99 || ib.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_n1 a=%h b_valid=%b want ab99 0", ia.rsp_rdata, ib.rsp_valid); end
      drive(0, 0, 0, 0, 0); tick;
      n_vec++; if (ib.rsp_valid !== 1'b1 || ib.rsp_rdata !== 16'h1234 || ia.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_lat3 b=%b/%h a_valid=%b want 1/1234 0", ib.rsp_valid, ib.rsp_rdata, ia.rsp_valid); end
      tick;
      n_vec++; if (ib.rsp_valid !== 1'b1 || ib.rsp_rdata !== 16'hAB99) begin n_bad++; $display("FAIL b2b_lat4 got %b/%h want 1/ab99", ib.rsp_valid, ib.rsp_rdata); end
      tick;
      n_vec++; if (ib.rsp_valid !== 1'b0 || ib.rsp_rdata !== 16'hAB99) begin n_bad++; $display("FAIL b2b_hold got %b/%h want 0/ab99", ib.rsp_valid, ib.rsp_rdata); end
   endtask

   task automatic test_reset_mid_clear;
      int  cnt = 0;
      logic c_busy = 1'b0;
      rst = 1'b1; tick; rst = 1'b0;
      repeat (100) tick;
      n_vec++; if (ia.busy !== 1'b1) begin n_bad++; $display("FAIL mid_clear_busy got %b want 1", ia.busy); end
      rst = 1'b1; tick; rst = 1'b0; #1;
      n_vec++; if (ic.req_ready !== 1'b1) begin n_bad++; $display("FAIL nocl_ready got %b want 1", ic.req_ready); end
      while (ia.busy === 1'b1 && cnt < 1000) begin c_busy |= ic.busy; cnt++; tick; end
      n_vec++; if (cnt != 256) begin n_bad++; $display("FAIL restart_len got %0d want 256", cnt); end
      n_vec++; if (c_busy !== 1'b0) begin n_bad++; $display("FAIL nocl_busy got %b want 0", c_busy); end
      drive(1, 0, 8'h10, 0, 0); tick;
      n_vec++; if (ic.rsp_valid !== 1'b1 || ic.rsp_rdata !== 16'h5A5A) begin n_bad++; $display("FAIL keep_10_c got %b/%h want 1/5a5a", ic.rsp_valid, ic.rsp_rdata); end
      n_vec++; if (ia.rsp_rdata !== 16'h0000) begin n_bad++; $display("FAIL clr_10_a got %h want 0000", ia.rsp_rdata); end
      drive(1, 0, 8'h00, 0, 0); tick;
      n_vec++; if (ic.rsp_rdata !== 16'h1234 || ia.rsp_rdata !== 16'h0000) begin n_bad++; $display("FAIL keep_00 c=%h a=%h want 1234 0000", ic.rsp_rdata, ia.rsp_rdata); end
      drive(0, 0, 0, 0, 0); tick; tick; tick; tick;
   endtask

   task automatic test_flush;
      logic seen = 1'b0;
      drive(1, 0, 8'h00, 0, 0); tick;
      drive(1, 0, 8'hFF, 0, 0); tick;
      drive(0, 0, 0, 0, 0); rst = 1'b1; tick;
      rst = 1'b0;
      seen |= ib.rsp_valid;
      repeat (4) begin tick; seen |= ib.rsp_valid; end
      n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_pulse got %b want 0", seen); end
      n_vec++; if (ib.rsp_rdata !== 16'h0000) begin n_bad++; $display("FAIL flush_rdata got %h want 0000", ib.rsp_rdata); end
   endtask

   initial begin
      test_reset;
      test_raw;
      test_strobe;
      test_back_to_back;
      test_reset_mid_clear;
      test_flush;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
